// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: default opcodes, IR capture pattern and data-register select enum.
package jtag_pkg;

  localparam int unsigned IrWidthDefault = 4;

  localparam logic [7:0] OpExtestDefault = 8'h00;
  localparam logic [7:0] OpSampleDefault = 8'h01;
  localparam logic [7:0] OpIntestDefault = 8'h02;

  // IDCODE defaults to all-ones minus one so it never collides with BYPASS.
  function automatic logic [7:0] op_idcode_default(int unsigned width);
    return 8'((1 << width) - 2);
  endfunction

  // Fixed 2'b01 in the low bits, zero-extended; the caller truncates to IR_WIDTH.
  function automatic logic [7:0] ir_capture_pattern();
    return 8'b0000_0001;
  endfunction

  typedef enum logic [1:0] {
    TDR_BSR,
    TDR_BYPASS,
    TDR_IDCODE
  } tdr_sel_e;

endpackage

// File: rtl/jtag_ir_decode.sv
// Combinational decode of the active JTAG instruction into data-register selects.
module jtag_ir_decode
  import jtag_pkg::*;
#(
  parameter int unsigned           IR_WIDTH  = IrWidthDefault,
  parameter logic [IR_WIDTH-1:0]   OP_EXTEST = IR_WIDTH'(OpExtestDefault),
  parameter logic [IR_WIDTH-1:0]   OP_SAMPLE = IR_WIDTH'(OpSampleDefault),
  parameter logic [IR_WIDTH-1:0]   OP_INTEST = IR_WIDTH'(OpIntestDefault),
  parameter logic [IR_WIDTH-1:0]   OP_IDCODE = IR_WIDTH'(op_idcode_default(IR_WIDTH))
) (
  input  logic [IR_WIDTH-1:0] instr_i,
  output logic                sel_o,
  output logic                idcode_sel_o,
  output logic                bsr_sel_o,
  output logic                test_mode_o,
  output logic                intest_o
);

  tdr_sel_e tdr_sel;

  // Priority chain resolves colliding opcodes; anything unmatched falls to BYPASS.
  always_comb begin
    tdr_sel     = TDR_BYPASS;
    test_mode_o = 1'b0;
    intest_o    = 1'b0;
    if (instr_i == OP_EXTEST) begin
      tdr_sel     = TDR_BSR;
      test_mode_o = 1'b1;
    end else if (instr_i == OP_SAMPLE) begin
      tdr_sel = TDR_BSR;
    end else if (instr_i == OP_INTEST) begin
      tdr_sel     = TDR_BSR;
      test_mode_o = 1'b1;
      intest_o    = 1'b1;
    end else if (instr_i == OP_IDCODE) begin
      tdr_sel = TDR_IDCODE;
    end
  end

  assign bsr_sel_o    = (tdr_sel == TDR_BSR);
  assign sel_o        = (tdr_sel == TDR_BYPASS);
  assign idcode_sel_o = (tdr_sel == TDR_IDCODE);

endmodule

// File: rtl/jtag_instruction_register.sv
// JTAG instruction register: serial shift stage, parallel update stage and instruction decode.
module jtag_instruction_register
  import jtag_pkg::*;
#(
  parameter int unsigned           IR_WIDTH  = IrWidthDefault,
  parameter logic [IR_WIDTH-1:0]   OP_EXTEST = IR_WIDTH'(OpExtestDefault),
  parameter logic [IR_WIDTH-1:0]   OP_SAMPLE = IR_WIDTH'(OpSampleDefault),
  parameter logic [IR_WIDTH-1:0]   OP_INTEST = IR_WIDTH'(OpIntestDefault),
  parameter logic [IR_WIDTH-1:0]   OP_IDCODE = IR_WIDTH'(op_idcode_default(IR_WIDTH))
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tdi,
  input  logic                tlr,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  output logic                ir_tdo,
  output logic [IR_WIDTH-1:0] instruction,
  output logic                sel,
  output logic                idcode_sel,
  output logic                bsr_sel,
  output logic                test_mode,
  output logic                intest
);

  if (IR_WIDTH < 2 || IR_WIDTH > 8) begin : g_bad_width
    $error("IR_WIDTH must be in 2..8");
  end

  localparam logic [IR_WIDTH-1:0] CapturePattern = IR_WIDTH'(ir_capture_pattern());

  logic [IR_WIDTH-1:0] sr_q, sr_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;

  always_comb begin
    sr_d    = sr_q;
    instr_d = instr_q;
    if (tlr) begin
      sr_d    = OP_IDCODE;
      instr_d = OP_IDCODE;
    end else begin
      // Update samples the shift stage as it stood before this edge's capture/shift.
      if (update_ir) instr_d = sr_q;
      if (capture_ir) begin
        sr_d = CapturePattern;
      end else if (shift_ir) begin
        sr_d = {tdi, sr_q[IR_WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      sr_q    <= OP_IDCODE;
      instr_q <= OP_IDCODE;
    end else begin
      sr_q    <= sr_d;
      instr_q <= instr_d;
    end
  end

  assign ir_tdo      = sr_q[0];
  assign instruction = instr_q;

  jtag_ir_decode #(
    .IR_WIDTH  (IR_WIDTH),
    .OP_EXTEST (OP_EXTEST),
    .OP_SAMPLE (OP_SAMPLE),
    .OP_INTEST (OP_INTEST),
    .OP_IDCODE (OP_IDCODE)
  ) u_decode (
    .instr_i      (instr_q),
    .sel_o        (sel),
    .idcode_sel_o (idcode_sel),
    .bsr_sel_o    (bsr_sel),
    .test_mode_o  (test_mode),
    .intest_o     (intest)
  );

endmodule

// File: tb/tb_jtag_instruction_register.sv
// Randomized bench for jtag_instruction_register against an arithmetic reference model.
module tb_jtag_instruction_register;

  localparam int W  = 4;
  localparam int ID = 14;

  logic         tck = 1'b0;
  logic         trst_n = 1'b1;
  logic         tdi = 1'b0;
  logic         tlr = 1'b0;
  logic         capture_ir = 1'b0;
  logic         shift_ir = 1'b0;
  logic         update_ir = 1'b0;
  logic         ir_tdo;
  logic [W-1:0] instruction;
  logic         sel, idcode_sel, bsr_sel, test_mode, intest;

  int n_checks = 0;
  int n_errors = 0;
  int m_sr = ID;
  int m_ir = ID;

  jtag_instruction_register #(.IR_WIDTH(W)) dut (
    .tck         (tck),
    .trst_n      (trst_n),
    .tdi         (tdi),
    .tlr         (tlr),
    .capture_ir  (capture_ir),
    .shift_ir    (shift_ir),
    .update_ir   (update_ir),
    .ir_tdo      (ir_tdo),
    .instruction (instruction),
    .sel         (sel),
    .idcode_sel  (idcode_sel),
    .bsr_sel     (bsr_sel),
    .test_mode   (test_mode),
    .intest      (intest)
  );

  always #5 tck = ~tck;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {sel, idcode_sel, bsr_sel, test_mode, intest} per opcode table.
  function automatic logic [4:0] exp_decode(int op);
    case (op)
      0:       return 5'b00110;
      1:       return 5'b00100;
      2:       return 5'b00111;
      ID:      return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  task automatic check_all();
    check_eq("ir_tdo", 32'(ir_tdo), 32'(m_sr % 2));
    check_eq("instruction", 32'(instruction), 32'(m_ir));
    check_eq("decode", 32'({sel, idcode_sel, bsr_sel, test_mode, intest}),
             32'(exp_decode(m_ir)));
    check_eq("one_hot", 32'(int'(sel) + int'(idcode_sel) + int'(bsr_sel)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge tck);
    if (trst_n) begin
      if (tlr) begin
        m_sr = ID;
        m_ir = ID;
      end else begin
        if (update_ir) m_ir = m_sr;
        if (capture_ir) m_sr = 1;
        else if (shift_ir) m_sr = (m_sr / 2) + (int'(tdi) * (1 << (W - 1)));
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic c, input logic s, input logic u, input logic t, input logic d);
    capture_ir = c;
    shift_ir   = s;
    update_ir  = u;
    tlr        = t;
    tdi        = d;
  endtask

  task automatic shift_bits(input int val, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'((val >> i) & 1));
      cycle();
    end
  endtask

  task automatic load_ir(input int val);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    shift_bits(val, W);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    trst_n = 1'b0;
    #1;
    m_sr = ID;
    m_ir = ID;
    check_all();
    cycle();
    trst_n = 1'b1;
  endtask

  initial begin
    #1;
    apply_reset();
    cycle();
    check_eq("rst_instr", 32'(instruction), 32'hE);
    check_eq("rst_idcode_sel", 32'(idcode_sel), 32'd1);

    // EXTEST via captured pattern shifted out LSB-first.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("cap_tdo", 32'(ir_tdo), 32'd1);
    shift_bits(0, W);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("extest_instr", 32'(instruction), 32'h0);
    check_eq("extest_bsr", 32'(bsr_sel), 32'd1);
    check_eq("extest_tm", 32'(test_mode), 32'd1);

    load_ir(2);
    check_eq("intest_flag", 32'(intest), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    shift_bits(15, W);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_eq("hold_instr", 32'(instruction), 32'h2);

    load_ir(7);
    check_eq("unlisted_sel", 32'(sel), 32'd1);

    // tlr wins over a simultaneous update.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    shift_bits(1, W);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    check_eq("tlr_over_update", 32'(instruction), 32'hE);

    // Reset mid-shift discards the partial shift.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    shift_bits(5, 2);
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("midshift_rst_instr", 32'(instruction), 32'hE);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        apply_reset();
      end else begin
        drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 29) == 0),
              1'($urandom_range(0, 1)));
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtag_instruction_register.md
JTAG_INSTRUCTION_REGISTER -- requirements
Module: jtag_instruction_register

Interface
REQ-001 Parameter IR_WIDTH, default 4, sets the instruction length in bits; legal range is 2..8.
REQ-002 Parameter OP_EXTEST, default all-zeros, is the EXTEST opcode.
REQ-003 Parameter OP_SAMPLE, default 1, is the SAMPLE/PRELOAD opcode.
REQ-004 Parameter OP_INTEST, default 2, is the INTEST opcode.
REQ-005 Parameter OP_IDCODE, default 2^IR_WIDTH-2, is the IDCODE opcode.
REQ-006 The BYPASS opcode is fixed at all-ones and is not a parameter.
REQ-007 Port tck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port trst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port tdi, input, 1 bit: serial data in.
REQ-010 Port tlr, input, 1 bit: the TAP controller is in Test-Logic-Reset.
REQ-011 Port capture_ir, input, 1 bit: the TAP controller is in Capture-IR.
REQ-012 Port shift_ir, input, 1 bit: the TAP controller is in Shift-IR.
REQ-013 Port update_ir, input, 1 bit: the TAP controller is in Update-IR.
REQ-014 Port ir_tdo, output, 1 bit: serial data out.
REQ-015 Port instruction, output, IR_WIDTH bits: the active instruction from the update stage.
REQ-016 Port sel, output, 1 bit: BYPASS register selected.
REQ-017 Port idcode_sel, output, 1 bit: IDCODE register selected.
REQ-018 Port bsr_sel, output, 1 bit: boundary-scan register selected.
REQ-019 Port test_mode, output, 1 bit: boundary cells drive the pins/core (EXTEST or INTEST).
REQ-020 Port intest, output, 1 bit: the active instruction is INTEST.

Function
REQ-021 The block SHALL hold two registers: a shift stage sr[IR_WIDTH-1:0] and an update stage instruction[IR_WIDTH-1:0].
- sr is the serial scan path.
- instruction is what the decode outputs are driven from.
REQ-022 sr updates on the rising edge of tck with this priority: tlr > capture_ir > shift_ir > hold.
REQ-023 On capture_ir, sr SHALL load the capture pattern {zeros, 2'b01}, which is 4'b0001 for IR_WIDTH=4.
REQ-024 On shift_ir, sr SHALL shift LSB-first: sr <= {tdi, sr[IR_WIDTH-1:1]}.
REQ-025 ir_tdo SHALL equal sr[0] combinationally and SHALL NOT be gated by shift_ir.
REQ-026 On update_ir with tlr low, instruction SHALL load sr; the new value is visible one tck edge after update_ir is sampled.
REQ-027 While update_ir is low, instruction SHALL hold its value through any capture or shift.
REQ-028 When tlr is high, sr and instruction SHALL both load OP_IDCODE on the next tck edge, overriding every other input.
REQ-029 If more than one of capture_ir, shift_ir and update_ir is asserted at once, REQ-022 governs sr and update_ir still governs instruction.
REQ-030 The decode outputs SHALL be a function of instruction only:
- EXTEST gives bsr_sel=1, test_mode=1.
- SAMPLE gives bsr_sel=1.
- INTEST gives bsr_sel=1, test_mode=1, intest=1.
- IDCODE gives idcode_sel=1.
- BYPASS and every unlisted opcode give sel=1.
- Every output not named for an opcode is 0.
REQ-031 Exactly one of sel, idcode_sel and bsr_sel SHALL be high in every cycle, including during reset.
REQ-032 If parameter opcodes collide, the first match in the order EXTEST, SAMPLE, INTEST, IDCODE SHALL win; BYPASS always loses.

Reset
REQ-033 On trst_n low, sr and instruction SHALL take OP_IDCODE immediately, asynchronously.
REQ-034 The output values during reset SHALL be: idcode_sel=1; sel, bsr_sel, test_mode and intest=0; ir_tdo = OP_IDCODE[0].
REQ-035 Reset asserted mid-shift SHALL discard the partial shift; no update occurs when trst_n rises.
REQ-036 Deassertion of trst_n SHALL take effect on the first tck rising edge after release.

Structure
REQ-037 The shared package jtag_pkg SHALL hold the default opcode constants, the capture pattern function and the TDR-select enum {TDR_BSR, TDR_BYPASS, TDR_IDCODE}.
REQ-038 The decode SHALL be a combinational sub-module, jtag_ir_decode, instantiated once.

Verification (IR_WIDTH=4, default opcodes)
REQ-039 Pulse trst_n low, then release -> instruction=4'hE, idcode_sel=1, all other selects 0.
REQ-040 Capture_ir for 1 cycle, then shift_ir for 4 cycles with tdi=0,0,0,0 -> ir_tdo=1,0,0,0; then update_ir -> instruction=4'h0, bsr_sel=1, test_mode=1.
REQ-041 Shift in 4'h2 (tdi=0,1,0,0), then update_ir -> intest=1, test_mode=1; then capture and shift 4'hF without update -> instruction stays 4'h2.
REQ-042 Shift in 4'h7 (unlisted), then update_ir -> sel=1, bsr_sel=0, idcode_sel=0.
REQ-043 Assert tlr together with update_ir after shifting 4'h1 -> instruction=4'hE, not 4'h1.
REQ-044 Assert trst_n low after 2 of 4 shift cycles -> sr=4'hE immediately; release, then update_ir -> instruction=4'hE.
